// File: rtl/risc_pkg.sv
// Shared constants, field positions and fetch-state encoding for the 16-bit RISC core.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int F1_MSB  = 7;
  localparam int F1_LSB  = 4;
  localparam int F0_MSB  = 3;
  localparam int F0_LSB  = 0;

  localparam logic [3:0]         OPC_HALT = 4'hF;
  localparam logic [INSTR_W-1:0] NOP      = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } ifu_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus the decode valid/ready port and IR fields.
interface instr_fetch_unit_if;
  import risc_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [3:0]         rd;
  logic [3:0]         instr7_4;
  logic [3:0]         instr3_0;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, dec_valid, instr, opcode, rd, instr7_4, instr3_0, pc_out,
    input  imem_rdata, imem_ack, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, instr, opcode, rd, instr7_4, instr3_0, pc_out,
    output imem_rdata, imem_ack, dec_ready
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset load, modulo-2^16 increment, and redirect load (redirect has priority).
module ifu_pc_reg
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: IDLE/FETCH/HOLD sequencer, instruction register and decode handshake.
// Optional halt detection (opcode 4'hF) is built when IFU_HALT_DETECT_EN is defined.
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_unit_if.master bus
`ifdef IFU_HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  ifu_state_e         state_q;
  logic               req_q;
  logic               valid_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  pc_out_q;
  logic [ADDR_W-1:0]  pc_s;
  logic               take_s;

  // An ack is only consumed for a live request that is not being redirected away.
  assign take_s = (state_q == FETCH) && req_q && bus.imem_ack && !redirect;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect),
    .load_pc_i (redirect_pc),
    .inc_i     (take_s),
    .pc_o      (pc_s)
  );

`ifdef IFU_HALT_DETECT_EN
  logic halted_q;
`endif

  // Fetch sequencer with registered request, valid, IR and pc_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      ir_q     <= NOP;
      pc_out_q <= 16'h0000;
`ifdef IFU_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else if (redirect) begin
      // Leaving FETCH forces a one-cycle request gap so the abandoned request is visibly closed.
      state_q  <= en ? FETCH : IDLE;
      req_q    <= en && (state_q != FETCH);
      valid_q  <= 1'b0;
      ir_q     <= NOP;
`ifdef IFU_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            ir_q     <= bus.imem_rdata;
            pc_out_q <= pc_s;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.dec_ready) begin
            valid_q <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
            if (opcode_of(ir_q) == OPC_HALT) begin
              state_q  <= HALTED;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end else
`endif
            if (en) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
`ifdef IFU_HALT_DETECT_EN
        HALTED: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_s;
  assign bus.dec_valid = valid_q;
  assign bus.instr     = ir_q;
  assign bus.opcode    = opcode_of(ir_q);
  assign bus.rd        = ir_q[RD_MSB:RD_LSB];
  assign bus.instr7_4  = ir_q[F1_MSB:F1_LSB];
  assign bus.instr3_0  = ir_q[F0_MSB:F0_LSB];
  assign bus.pc_out    = pc_out_q;

`ifdef IFU_HALT_DETECT_EN
  assign halted = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios, then randomized traffic against a
// transaction-level model (expected next fetch address, held instruction, pc_out).
module tb_instr_fetch_unit;
  import risc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en, redirect;
  logic [15:0] redirect_pc;
  logic        en2, redirect2;
  logic [15:0] redirect_pc2;
`ifdef IFU_HALT_DETECT_EN
  logic halted, halted2;
`endif

  instr_fetch_unit_if ifc ();
  instr_fetch_unit_if ifc2 ();

  instr_fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect), .redirect_pc(redirect_pc), .bus(ifc)
`ifdef IFU_HALT_DETECT_EN
    , .halted(halted)
`endif
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF), .PC_INC(16'h0001)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .redirect(redirect2), .redirect_pc(redirect_pc2), .bus(ifc2)
`ifdef IFU_HALT_DETECT_EN
    , .halted(halted2)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory contents: address 0 holds 16'h1A85; other words never carry opcode 4'hF.
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'h0000) begin
      w = 16'h1A85;
    end else begin
      w = (a * 16'h9E37) ^ 16'h5A5A;
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
    end
    return w;
  endfunction

  function automatic logic [15:0] data_at(input logic [15:0] a);
    return ovr_en ? ovr_val : mem_word(a);
  endfunction

  // Stimulus knobs
  logic        d_en = 1'b0, d_ready = 1'b0, d_redir = 1'b0, d_ack = 1'b0;
  logic [15:0] d_rpc = 16'h0000;
  logic        auto_mem = 1'b0;
  int          age = 0, delay = 0;

  // Reference model
  logic [15:0] m_next, m_instr, m_pc_out;
  logic        m_valid, m_halted;
  int          idle_cnt, consumed;
  logic        dut2_done = 1'b0;

  task automatic model_reset();
    m_next = 16'h0000; m_instr = 16'h0000; m_pc_out = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; idle_cnt = 0; age = 0;
  endtask

  task automatic compare();
    chk("dec_valid", ifc.dec_valid, m_valid);
    chk("instr", ifc.instr, m_instr);
    chk("opcode", ifc.opcode, m_instr[15:12]);
    chk("rd", ifc.rd, m_instr[11:8]);
    chk("instr7_4", ifc.instr7_4, m_instr[7:4]);
    chk("instr3_0", ifc.instr3_0, m_instr[3:0]);
    chk("pc_out", ifc.pc_out, m_pc_out);
    if (ifc.imem_req) chk("imem_addr", ifc.imem_addr, m_next);
    chk("req_while_holding", ifc.imem_req && (m_valid || m_halted), 1'b0);
    if (en && !m_valid && !m_halted && !ifc.imem_req) idle_cnt++;
    else idle_cnt = 0;
    chk("fetch_stall", idle_cnt > 2, 1'b0);
`ifdef IFU_HALT_DETECT_EN
    chk("halted", halted, m_halted);
`endif
  endtask

  // Drive at the current negedge, advance the model at posedge, compare at the next negedge.
  task automatic cyc();
    logic ack;
    logic req_seen;
    req_seen = ifc.imem_req;
    if (auto_mem) begin
      if (req_seen) begin
        if (age == 0) delay = $urandom_range(0, 3);
        ack = (age >= delay);
        age = ack ? 0 : age + 1;
      end else begin
        age = 0;
        ack = 1'b0;
      end
    end else begin
      ack = d_ack && req_seen;
    end
    en = d_en; ifc.dec_ready = d_ready; redirect = d_redir; redirect_pc = d_rpc;
    ifc.imem_ack = ack;
    ifc.imem_rdata = ack ? data_at(ifc.imem_addr) : 16'hDEAD;
    @(posedge clk);
    if (d_redir) begin
      m_next = d_rpc; m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
    end else if (ack) begin
      m_valid = 1'b1; m_instr = data_at(m_next); m_pc_out = m_next; m_next = m_next + 16'h0001;
    end else if (m_valid && d_ready) begin
      m_valid = 1'b0;
      consumed++;
`ifdef IFU_HALT_DETECT_EN
      if (m_instr[15:12] == 4'hF) m_halted = 1'b1;
`endif
    end
    @(negedge clk);
    compare();
  endtask

  // Second instance: RESET_PC = 16'hFFFF, always ready, ack follows request.
  initial begin
    int   rises;
    logic prev;
    en2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 16'h0000;
    ifc2.imem_ack = 1'b0; ifc2.imem_rdata = 16'h1234; ifc2.dec_ready = 1'b1;
    rises = 0; prev = 1'b0;
    @(posedge rst_n);
    for (int k = 0; k < 40 && rises < 2; k++) begin
      @(negedge clk);
      if (ifc2.imem_req && !prev) begin
        rises++;
        if (rises == 1) begin
          chk("pc2_first_addr", ifc2.imem_addr, 16'hFFFF);
        end else begin
          chk("pc2_wrap_addr", ifc2.imem_addr, 16'h0000);
          chk("pc2_pc_out", ifc2.pc_out, 16'hFFFF);
        end
      end
      prev = ifc2.imem_req;
      ifc2.imem_ack = ifc2.imem_req;
    end
    if (rises < 2) chk("pc2_timeout", rises, 2);
    dut2_done = 1'b1;
  end

  initial begin
    en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    ifc.dec_ready = 1'b0; ifc.imem_ack = 1'b0; ifc.imem_rdata = 16'h0000;
    consumed = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", ifc.imem_req, 1'b0);
    chk("rst_valid", ifc.dec_valid, 1'b0);
    chk("rst_instr", ifc.instr, 16'h0000);
    chk("rst_pc_out", ifc.pc_out, 16'h0000);
    chk("rst_addr", ifc.imem_addr, 16'h0000);
    rst_n = 1'b1;
    compare();

    // First fetch at address 0, single-cycle ack
    d_en = 1'b1; cyc();
    chk("f1_req", ifc.imem_req, 1'b1);
    chk("f1_addr", ifc.imem_addr, 16'h0000);
    d_ack = 1'b1; cyc();
    chk("f1_valid", ifc.dec_valid, 1'b1);
    chk("f1_opcode", ifc.opcode, 4'h1);
    chk("f1_rd", ifc.rd, 4'hA);
    chk("f1_i74", ifc.instr7_4, 4'h8);
    chk("f1_i30", ifc.instr3_0, 4'h5);
    chk("f1_pc_out", ifc.pc_out, 16'h0000);
    chk("model_pin_instr", m_instr, 16'h1A85);

    // Decode stalls for 5 cycles
    d_ack = 1'b0; d_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("stall_valid", ifc.dec_valid, 1'b1);
      chk("stall_instr", ifc.instr, 16'h1A85);
      chk("stall_req", ifc.imem_req, 1'b0);
    end
    d_ready = 1'b1; cyc();
    chk("f2_valid_drop", ifc.dec_valid, 1'b0);
    chk("f2_req", ifc.imem_req, 1'b1);
    chk("f2_addr", ifc.imem_addr, 16'h0001);

    // Ack delayed 3 cycles
    d_ready = 1'b0; d_ack = 1'b0;
    repeat (3) begin
      cyc();
      chk("slow_req", ifc.imem_req, 1'b1);
      chk("slow_addr", ifc.imem_addr, 16'h0001);
    end
    d_ack = 1'b1; cyc();
    chk("slow_instr", ifc.instr, 16'hC46D);
    chk("slow_pc_out", ifc.pc_out, 16'h0001);
    d_ack = 1'b0; cyc();
    chk("slow_single_load", ifc.dec_valid, 1'b1);

    // Redirect during FETCH with a simultaneous ack
    d_ready = 1'b1; cyc();
    chk("rd_fetch_addr", ifc.imem_addr, 16'h0002);
    d_ready = 1'b0; d_ack = 1'b1; d_redir = 1'b1; d_rpc = 16'h0040; cyc();
    chk("redir_valid", ifc.dec_valid, 1'b0);
    chk("redir_nop", ifc.instr, 16'h0000);
    chk("redir_gap", ifc.imem_req, 1'b0);
    chk("model_pin_next", m_next, 16'h0040);
    d_ack = 1'b0; d_redir = 1'b0; cyc();
    chk("redir_req", ifc.imem_req, 1'b1);
    chk("redir_addr", ifc.imem_addr, 16'h0040);
    d_ack = 1'b1; cyc();
    chk("redir_instr", ifc.instr, 16'hD79A);
    chk("redir_pc_out", ifc.pc_out, 16'h0040);
    d_ack = 1'b0; d_ready = 1'b1; cyc();
    d_ready = 1'b0;

    // Asynchronous reset in the middle of FETCH
    chk("pre_rst_req", ifc.imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", ifc.imem_req, 1'b0);
    chk("arst_valid", ifc.dec_valid, 1'b0);
    chk("arst_instr", ifc.instr, 16'h0000);
    chk("arst_pc_out", ifc.pc_out, 16'h0000);
    chk("arst_addr", ifc.imem_addr, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare();

`ifdef IFU_HALT_DETECT_EN
    ovr_en = 1'b1; ovr_val = 16'hF000; d_en = 1'b1; d_ack = 1'b1;
    cyc(); cyc();
    chk("halt_fetched", ifc.instr, 16'hF000);
    ovr_en = 1'b0; d_ready = 1'b1; cyc();
    chk("halt_flag", halted, 1'b1);
    repeat (4) begin
      cyc();
      chk("halt_no_req", ifc.imem_req, 1'b0);
    end
    d_redir = 1'b1; d_rpc = 16'h0100; d_ack = 1'b0; cyc();
    chk("halt_clear", halted, 1'b0);
    chk("halt_resume_addr", ifc.imem_addr, 16'h0100);
    d_redir = 1'b0; d_ready = 1'b0;
`endif

    // Randomized traffic
    auto_mem = 1'b1;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      d_en    = ($urandom_range(0, 9) != 0);
      d_ready = $urandom_range(0, 1);
      d_redir = ($urandom_range(0, 19) == 0);
      d_rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cyc();
    end
    chk("random_progress", consumed > 100, 1'b1);

    for (int k = 0; k < 100 && !dut2_done; k++) @(negedge clk);
    chk("dut2_done", dut2_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit RISC core: sequences the PC, reads instruction memory over a req/ack handshake, and holds the fetched word in the instruction register (IR).
- Exposes the IR split into fields. instr7_4 and instr3_0 feed the downstream sign extender directly.
- Delivers instructions to decode via a valid/ready handshake. Supports PC redirect for branches and jumps.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 1, PC increment per instruction (word-addressed memory).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  fetch enable.
- imem_req  output  1  instruction memory request.
- imem_addr  output  16  fetch address.
- imem_rdata  input  16  instruction word; valid when imem_ack=1.
- imem_ack  input  1  memory data valid; may arrive 1..N cycles after the request.
- dec_valid  output  1  IR holds an instruction for decode.
- dec_ready  input  1  decode accepts the instruction.
- instr  output  16  full IR.
- opcode  output  4  IR[15:12].
- rd  output  4  IR[11:8].
- instr7_4  output  4  IR[7:4], to the sign extender.
- instr3_0  output  4  IR[3:0], to the sign extender.
- pc_out  output  16  address the current IR was fetched from.
- redirect  input  1  load a new PC (branch or jump taken).
- redirect_pc  input  16  redirect target.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE, pc = RESET_PC, IR = 16'h0000, pc_out = 16'h0000.
  - imem_req = 0, dec_valid = 0.
  - Field outputs are combinational slices of the IR, so all read 0 in reset.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - imem_req = 0, dec_valid = 0.
  - en=1 → FETCH on the next cycle.
- FETCH:
  - imem_req = 1, imem_addr = pc. Both are held stable until imem_ack.
  - On imem_ack: IR ← imem_rdata, pc_out ← pc, pc ← pc + PC_INC (wraps modulo 2^16, 16'hFFFF → 16'h0000), dec_valid ← 1, go to HOLD.
  - Deasserting en during FETCH does not abort the request; the fetch completes normally.
- HOLD:
  - dec_valid = 1. IR and pc_out are stable while dec_ready = 0.
  - dec_ready=1 → dec_valid ← 0, then FETCH if en=1, else IDLE.
- Throughput: at most one instruction per 2 cycles with single-cycle ack. Fetch-to-dec_valid latency is 1 cycle after ack.
- Redirect (highest priority, any state):
  - pc ← redirect_pc, dec_valid ← 0, IR ← 16'h0000 (NOP).
  - Next state is FETCH if en=1, else IDLE.
  - An imem_ack in the same cycle is discarded.
  - A request outstanding in FETCH is abandoned: imem_req drops for one cycle, then reissues at the new address.
  - The memory must not deliver a late ack for an abandoned request.
- Simultaneous redirect and dec_ready in HOLD: redirect wins. The held instruction counts as consumed; no duplicate.
- Reset mid-operation: immediate return to reset values; an outstanding request is dropped.

Optional Feature:
- Macro: IFU_HALT_DETECT_EN.
- Defined:
  - Adds output port halted (1 bit) and state HALTED.
  - When an instruction with opcode 4'hF is accepted (HOLD with dec_ready=1), the FSM enters HALTED.
  - In HALTED: imem_req = 0, dec_valid = 0, halted = 1. The FSM stays there until redirect (goes to FETCH/IDLE per en) or reset.
- Not defined: no halted port; opcode 4'hF is fetched like any other instruction.

Decomposition:
- Shared package risc_pkg holds:
  - Constants: INSTR_W=16, ADDR_W=16, opcode field positions, OPC_HALT=4'hF, NOP=16'h0000.
  - State encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, HALTED=2'd3.
- Sub-module: ifu_pc_reg, the PC register with increment, wrap and redirect-load. No other split.

Test Plan:
- Reset, then en=1, memory returns 16'h1A85 with 1-cycle ack at address 0 → dec_valid=1 one cycle after ack; opcode=1, rd=A, instr7_4=8, instr3_0=5, pc_out=0; next imem_addr=1.
- dec_ready held low for 5 cycles → IR, pc_out and dec_valid stable; no imem_req until dec_ready=1.
- Ack delayed 3 cycles → imem_req and imem_addr stable throughout; a single IR load.
- Redirect to 16'h0040 while in FETCH, with ack in the same cycle → ack data discarded; next request at 16'h0040; dec_valid=0.
- RESET_PC=16'hFFFF, fetch one instruction → following imem_addr=16'h0000.
- rst_n pulsed low mid-FETCH → outputs return to reset values asynchronously. With IFU_HALT_DETECT_EN defined, accepting 16'hF000 → halted=1 and no further imem_req until redirect.
